// File: rtl/multi_digit_seg_counter.sv
// -----------------------------------------------------------------------------
// multi_digit_seg_counter
//
// Free-running tick counter with a multiplexed multi-digit 7-segment display.
// A prescaler produces a one-cycle tick every CLK_FREQ/TICK_HZ clocks. Each
// tick steps a DIGITS-nibble count up or down, in hex or BCD, and toggles a
// heartbeat LED. A second, independent divider scans the count onto a shared
// segment bus with one-hot digit selects.
//
// Parameters
//   CLK_FREQ  input clock frequency in Hz
//   TICK_HZ   count rate in Hz (TICK_DIV = CLK_FREQ/TICK_HZ, clamped to >= 1)
//   SCAN_HZ   full display refresh rate (SCAN_DIV = CLK_FREQ/(SCAN_HZ*DIGITS))
//   DIGITS    number of digits / count nibbles, 1..8
//   DECIMAL   0 = hex nibbles, 1 = BCD nibbles
//   BLANK_LZ  1 = blank leading-zero digits (digit 0 is always shown)
//
// Ports
//   CLK       system clock, rising edge
//   RST_N     asynchronous active-low reset
//   EN        1 = run prescaler and count, 0 = freeze both
//   UP_DN     1 = count up, 0 = count down (sampled on the tick)
//   CLR       synchronous clear of count, LED, prescaler and WRAP
//   LOAD      synchronous load of D into the count
//   D         load value, nibble k -> digit k
//   VALUE     current count
//   LED       heartbeat, toggles on every counted tick
//   WRAP      one-cycle pulse on the step that wraps the count
//   DIG_SEL   one-hot active-high digit enable
//   Segment   active-high segments, [6:0] = g..a, [7] = DP (always 0)
// -----------------------------------------------------------------------------
module multi_digit_seg_counter #(
  parameter int CLK_FREQ = 125_000_000,
  parameter int TICK_HZ  = 1,
  parameter int SCAN_HZ  = 1000,
  parameter int DIGITS   = 4,
  parameter int DECIMAL  = 0,
  parameter int BLANK_LZ = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic                  UP_DN,
  input  logic                  CLR,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   VALUE,
  output logic                  LED,
  output logic                  WRAP,
  output logic [DIGITS-1:0]     DIG_SEL,
  output logic [7:0]            Segment
);

  localparam int W = 4 * DIGITS;

  // A tick rate above the clock rate would give a zero divider; clamp so the
  // prescaler always has at least one state.
  localparam int TICK_DIV_RAW = CLK_FREQ / TICK_HZ;
  localparam int TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
  localparam int SCAN_DIV_RAW = CLK_FREQ / (SCAN_HZ * DIGITS);
  localparam int SCAN_DIV     = (SCAN_DIV_RAW < 1) ? 1 : SCAN_DIV_RAW;
  localparam int IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [31:0]      TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [31:0]      SCAN_LAST = 32'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Hex nibble to active-high segments {dp, g, f, e, d, c, b, a}.
  function automatic logic [7:0] seg_encode(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0:    s = 8'h3F;
      4'h1:    s = 8'h06;
      4'h2:    s = 8'h5B;
      4'h3:    s = 8'h4F;
      4'h4:    s = 8'h66;
      4'h5:    s = 8'h6D;
      4'h6:    s = 8'h7D;
      4'h7:    s = 8'h27;
      4'h8:    s = 8'h7F;
      4'h9:    s = 8'h6F;
      4'hA:    s = 8'h77;
      4'hB:    s = 8'h7C;
      4'hC:    s = 8'h39;
      4'hD:    s = 8'h5E;
      4'hE:    s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  // Plain modular step. Result MSB is the carry/borrow out of the top digit.
  function automatic logic [W:0] step_hex(input logic [W-1:0] v, input logic up);
    logic [W:0] r;
    if (up) begin
      r = {1'b0, v} + (W+1)'(1);
    end else begin
      r = {(v == '0), v - W'(1)};
    end
    return r;
  endfunction

  // Nibble-wise ripple carry/borrow. Out-of-range nibbles (loaded as-is)
  // saturate to 9 going down without borrowing, and roll to 0 with a carry
  // going up, so the counter settles back into valid BCD on its own.
  function automatic logic [W:0] step_bcd(input logic [W-1:0] v, input logic up);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   n;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      n = v[4*k +: 4];
      if (c) begin
        if (up) begin
          if (n >= 4'd9) begin
            n = 4'd0;
            c = 1'b1;
          end else begin
            n = n + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (n == 4'd0) begin
            n = 4'd9;
            c = 1'b1;
          end else if (n > 4'd9) begin
            n = 4'd9;
            c = 1'b0;
          end else begin
            n = n - 4'd1;
            c = 1'b0;
          end
        end
      end
      r[4*k +: 4] = n;
    end
    return {c, r};
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: prescaler -> registered tick (p1)
  // ---------------------------------------------------------------------------
  logic [31:0] presc_p0;
  logic        tick_p1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_p0 <= '0;
      tick_p1  <= 1'b0;
    end else if (CLR) begin
      presc_p0 <= '0;
      tick_p1  <= 1'b0;
    end else if (EN) begin
      if (presc_p0 == TICK_LAST) begin
        presc_p0 <= '0;
        tick_p1  <= 1'b1;
      end else begin
        presc_p0 <= presc_p0 + 32'd1;
        tick_p1  <= 1'b0;
      end
    end else begin
      // Paused: hold the phase, and drop any tick that was pending.
      tick_p1 <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: count update (CLR > LOAD > tick > hold)
  // ---------------------------------------------------------------------------
  logic [W:0] step_res;

  always_comb begin
    step_res = (DECIMAL != 0) ? step_bcd(VALUE, UP_DN) : step_hex(VALUE, UP_DN);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      VALUE <= '0;
      LED   <= 1'b0;
      WRAP  <= 1'b0;
    end else if (CLR) begin
      VALUE <= '0;
      LED   <= 1'b0;
      WRAP  <= 1'b0;
    end else if (LOAD) begin
      // A coincident tick is consumed here: no step, no LED toggle.
      VALUE <= D;
      WRAP  <= 1'b0;
    end else if (tick_p1 && EN) begin
      VALUE <= step_res[W-1:0];
      LED   <= ~LED;
      WRAP  <= step_res[W];
    end else begin
      WRAP  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: display scan (independent of EN/CLR/LOAD)
  // ---------------------------------------------------------------------------
  logic [31:0]      scan_cnt;
  logic [IDX_W-1:0] scan_idx;
  logic [DIGITS-1:0] blank;
  logic [DIGITS-1:0] sel_next;
  logic             zero_above;
  logic [3:0]       cur_nib;
  logic             cur_blank;

  always_comb begin
    // Walk from the top digit down; a digit is a leading zero only while
    // every digit above it (and itself) is zero.
    blank      = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (VALUE[4*k +: 4] == 4'd0);
      blank[k]   = zero_above & (BLANK_LZ != 0);
    end

    cur_nib   = VALUE[3:0];
    cur_blank = 1'b0;
    sel_next  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (scan_idx == IDX_W'(k)) begin
        cur_nib     = VALUE[4*k +: 4];
        cur_blank   = blank[k];
        sel_next[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      DIG_SEL  <= DIGITS'(1);
      Segment  <= 8'h3F;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + 32'd1;
      end
      // Select and segments are registered together so they never skew.
      DIG_SEL <= sel_next;
      Segment <= cur_blank ? 8'h00 : seg_encode(cur_nib);
    end
  end

endmodule

// File: tb/tb_multi_digit_seg_counter.sv
// -----------------------------------------------------------------------------
// Testbench for multi_digit_seg_counter.
// Three instances share clock, reset and control inputs:
//   u_hex : hex, 4 digits, TICK_DIV = 10, SCAN_DIV = 5
//   u_bcd : BCD, 2 digits, TICK_DIV = 10
//   u_blk : hex, 4 digits, leading-zero blanking, SCAN_DIV = 5
// Expected values are pushed to a scoreboard queue as stimulus is applied and
// popped against DUT outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_multi_digit_seg_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        up_dn;
  logic        clr;
  logic        load;
  logic [15:0] d4;
  logic [7:0]  d2;
  logic [15:0] d_blk;

  logic [15:0] hex_value;
  logic        hex_led;
  logic        hex_wrap;
  logic [3:0]  hex_sel;
  logic [7:0]  hex_seg;

  logic [7:0]  bcd_value;
  logic        bcd_led;
  logic        bcd_wrap;
  logic [1:0]  bcd_sel;
  logic [7:0]  bcd_seg;

  logic [15:0] blk_value;
  logic        blk_led;
  logic        blk_wrap;
  logic [3:0]  blk_sel;
  logic [7:0]  blk_seg;

  always #5 clk = ~clk;

  multi_digit_seg_counter #(
    .CLK_FREQ(20), .TICK_HZ(2), .SCAN_HZ(1), .DIGITS(4), .DECIMAL(0), .BLANK_LZ(0)
  ) u_hex (
    .CLK(clk), .RST_N(rst_n), .EN(en), .UP_DN(up_dn), .CLR(clr), .LOAD(load),
    .D(d4), .VALUE(hex_value), .LED(hex_led), .WRAP(hex_wrap),
    .DIG_SEL(hex_sel), .Segment(hex_seg)
  );

  multi_digit_seg_counter #(
    .CLK_FREQ(20), .TICK_HZ(2), .SCAN_HZ(1), .DIGITS(2), .DECIMAL(1), .BLANK_LZ(0)
  ) u_bcd (
    .CLK(clk), .RST_N(rst_n), .EN(en), .UP_DN(up_dn), .CLR(clr), .LOAD(load),
    .D(d2), .VALUE(bcd_value), .LED(bcd_led), .WRAP(bcd_wrap),
    .DIG_SEL(bcd_sel), .Segment(bcd_seg)
  );

  multi_digit_seg_counter #(
    .CLK_FREQ(20), .TICK_HZ(2), .SCAN_HZ(1), .DIGITS(4), .DECIMAL(0), .BLANK_LZ(1)
  ) u_blk (
    .CLK(clk), .RST_N(rst_n), .EN(en), .UP_DN(up_dn), .CLR(clr), .LOAD(load),
    .D(d_blk), .VALUE(blk_value), .LED(blk_led), .WRAP(blk_wrap),
    .DIG_SEL(blk_sel), .Segment(blk_seg)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h, nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Advance n rising edges, then settle 1 unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // CLR then LOAD on consecutive edges: prescaler ends at 1, so the next
  // count happens on the 10th edge after this task returns.
  task automatic load_aligned(input logic [15:0] v4, input logic [7:0] v2);
    clr = 1'b1;
    cyc(1);
    clr   = 1'b0;
    d4    = v4;
    d_blk = v4;
    d2    = v2;
    load  = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
    d4 = '0; d2 = '0; d_blk = '0;
    cyc(3);

    // Reset state
    push("rst_value", 32'h0); push("rst_led", 32'h0); push("rst_wrap", 32'h0);
    push("rst_sel", 32'h1);   push("rst_seg", 32'h3F);
    pop_check(32'(hex_value)); pop_check(32'(hex_led)); pop_check(32'(hex_wrap));
    pop_check(32'(hex_sel));   pop_check(32'(hex_seg));

    // Hex up count from reset release
    en = 1'b1; up_dn = 1'b1; rst_n = 1'b1;
    push("hex_e10_value", 32'h0);
    cyc(10); pop_check(32'(hex_value));
    push("hex_e11_value", 32'h1); push("hex_e11_led", 32'h1);
    cyc(1);  pop_check(32'(hex_value)); pop_check(32'(hex_led));
    push("hex_e21_value", 32'h2); push("hex_e21_led", 32'h0);
    cyc(10); pop_check(32'(hex_value)); pop_check(32'(hex_led));

    // Pause with prescaler at 4
    cyc(3);
    en = 1'b0;
    push("pause_value", 32'h2);
    cyc(25); pop_check(32'(hex_value));
    en = 1'b1;
    push("resume_e6_value", 32'h2);
    cyc(6);  pop_check(32'(hex_value));
    push("resume_e7_value", 32'h3); push("resume_e7_led", 32'h1);
    cyc(1);  pop_check(32'(hex_value)); pop_check(32'(hex_led));

    // Hex up wrap
    up_dn = 1'b1;
    load_aligned(16'hFFFF, 8'h00);
    push("hexup_pre", 32'hFFFF);
    cyc(9);  pop_check(32'(hex_value));
    push("hexup_value", 32'h0); push("hexup_wrap", 32'h1); push("hexup_led", 32'h1);
    cyc(1);  pop_check(32'(hex_value)); pop_check(32'(hex_wrap)); pop_check(32'(hex_led));
    push("hexup_wrap_end", 32'h0);
    cyc(1);  pop_check(32'(hex_wrap));

    // Hex down wrap
    up_dn = 1'b0;
    load_aligned(16'h0000, 8'h00);
    push("hexdn_value", 32'hFFFF); push("hexdn_wrap", 32'h1);
    cyc(10); pop_check(32'(hex_value)); pop_check(32'(hex_wrap));

    // CLR and LOAD together
    clr = 1'b1; load = 1'b1; d4 = 16'h1234;
    push("clrload_value", 32'h0); push("clrload_led", 32'h0);
    cyc(1);  pop_check(32'(hex_value)); pop_check(32'(hex_led));
    clr = 1'b0; load = 1'b0;

    // LOAD on a tick cycle
    up_dn = 1'b1;
    load_aligned(16'h0005, 8'h00);
    cyc(9);
    d4 = 16'h00AB; load = 1'b1;
    push("loadtick_value", 32'hAB); push("loadtick_led", 32'h0);
    cyc(1);  pop_check(32'(hex_value)); pop_check(32'(hex_led));
    load = 1'b0;
    push("loadtick_next", 32'hAC); push("loadtick_next_led", 32'h1);
    cyc(10); pop_check(32'(hex_value)); pop_check(32'(hex_led));

    // EN falling on the tick cycle
    load_aligned(16'h0010, 8'h00);
    cyc(9);
    en = 1'b0;
    push("endrop_value", 32'h10);
    cyc(1);  pop_check(32'(hex_value));
    en = 1'b1;
    push("endrop_held", 32'h10);
    cyc(10); pop_check(32'(hex_value));
    push("endrop_next", 32'h11);
    cyc(1);  pop_check(32'(hex_value));

    // BCD up wrap
    up_dn = 1'b1;
    load_aligned(16'h0000, 8'h98);
    push("bcd_99", 32'h99); push("bcd_99_led", 32'h1);
    cyc(10); pop_check(32'(bcd_value)); pop_check(32'(bcd_led));
    push("bcd_00", 32'h00); push("bcd_00_wrap", 32'h1);
    cyc(10); pop_check(32'(bcd_value)); pop_check(32'(bcd_wrap));
    push("bcd_00_wrap_end", 32'h0);
    cyc(1);  pop_check(32'(bcd_wrap));

    // BCD down wrap
    up_dn = 1'b0;
    push("bcd_dn_99", 32'h99); push("bcd_dn_wrap", 32'h1);
    cyc(9);  pop_check(32'(bcd_value)); pop_check(32'(bcd_wrap));

    // BCD down from invalid nibble
    load_aligned(16'h0000, 8'h0C);
    push("bcd_0c_dn", 32'h09); push("bcd_0c_wrap", 32'h0);
    cyc(10); pop_check(32'(bcd_value)); pop_check(32'(bcd_wrap));

    // Asynchronous reset mid-count
    up_dn = 1'b1; d4 = 16'h0007; d_blk = 16'h0007; load = 1'b1;
    push("pre_rst_value", 32'h7);
    cyc(1);  pop_check(32'(hex_value));
    load = 1'b0;
    cyc(3);
    #2;
    rst_n = 1'b0;
    #1;
    push("arst_value", 32'h0); push("arst_led", 32'h0); push("arst_wrap", 32'h0);
    push("arst_sel", 32'h1);   push("arst_seg", 32'h3F);
    push("arst_bcd_sel", 32'h1); push("arst_bcd_seg", 32'h3F);
    push("arst_blk_led", 32'h0); push("arst_blk_wrap", 32'h0);
    pop_check(32'(hex_value)); pop_check(32'(hex_led)); pop_check(32'(hex_wrap));
    pop_check(32'(hex_sel));   pop_check(32'(hex_seg));
    pop_check(32'(bcd_sel));   pop_check(32'(bcd_seg));
    pop_check(32'(blk_led));   pop_check(32'(blk_wrap));
    cyc(2);

    // Scan and leading-zero blanking, phase known from reset release
    en = 1'b0; d4 = 16'h1A3F; d_blk = 16'h0005; load = 1'b1; rst_n = 1'b1;
    cyc(1);
    load = 1'b0;
    push("scan_e2_sel", 32'h1); push("scan_e2_seg", 32'h71);
    push("blk_value", 32'h5);   push("blk_e2_seg", 32'h6D);
    cyc(1);  pop_check(32'(hex_sel)); pop_check(32'(hex_seg));
    pop_check(32'(blk_value)); pop_check(32'(blk_seg));
    push("scan_e5_sel", 32'h1);
    cyc(3);  pop_check(32'(hex_sel));
    push("scan_e6_sel", 32'h2); push("scan_e6_seg", 32'h4F); push("blk_e6_seg", 32'h00);
    cyc(1);  pop_check(32'(hex_sel)); pop_check(32'(hex_seg)); pop_check(32'(blk_seg));
    push("scan_e11_sel", 32'h4); push("scan_e11_seg", 32'h77); push("blk_e11_seg", 32'h00);
    cyc(5);  pop_check(32'(hex_sel)); pop_check(32'(hex_seg)); pop_check(32'(blk_seg));
    push("scan_e16_sel", 32'h8); push("scan_e16_seg", 32'h06); push("blk_e16_seg", 32'h00);
    cyc(5);  pop_check(32'(hex_sel)); pop_check(32'(hex_seg)); pop_check(32'(blk_seg));
    push("scan_e21_sel", 32'h1); push("scan_e21_seg", 32'h71); push("blk_e21_seg", 32'h6D);
    cyc(5);  pop_check(32'(hex_sel)); pop_check(32'(hex_seg)); pop_check(32'(blk_seg));

    // All-zero value: digit 0 still shows 0, digit 1 blanked
    d_blk = 16'h0000; load = 1'b1;
    cyc(1);
    load = 1'b0;
    push("blk_zero_sel0", 32'h1); push("blk_zero_seg0", 32'h3F);
    cyc(1);  pop_check(32'(blk_sel)); pop_check(32'(blk_seg));
    push("blk_zero_sel1", 32'h2); push("blk_zero_seg1", 32'h00);
    cyc(3);  pop_check(32'(blk_sel)); pop_check(32'(blk_seg));

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_digit_seg_counter.md
# multi_digit_seg_counter

Parametrised tick counter with a multiplexed multi-digit 7-segment display. It generates a 1-cycle tick every `CLK_FREQ/TICK_HZ` clocks. On each tick it counts up or down in hex or BCD across `DIGITS` nibbles, toggles a heartbeat LED, and scans the count onto a common segment bus with one-hot digit selects. It is the next-generation seconds/display block for board-level lab designs.

## Interface
- `CLK_FREQ`, 125_000_000: input clock frequency in Hz.
- `TICK_HZ`, 1: count rate in Hz. `TICK_DIV = CLK_FREQ/TICK_HZ` (truncating); elaboration must ensure `TICK_DIV >= 1`.
- `SCAN_HZ`, 1000: full display refresh rate. `SCAN_DIV = max(1, CLK_FREQ/(SCAN_HZ*DIGITS))`.
- `DIGITS`, 4: number of display digits / count nibbles, 1..8.
- `DECIMAL`, 0: 0 = hex count per nibble (0..F); 1 = BCD count per nibble (0..9).
- `BLANK_LZ`, 0: 1 = blank leading-zero digits. Digit 0 is never blanked.
- `CLK` input 1: system clock; all logic on rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `EN` input 1: 1 = run; 0 = freeze the prescaler and the count.
- `UP_DN` input 1: 1 = count up, 0 = count down; sampled at the tick.
- `CLR` input 1: synchronous clear.
- `LOAD` input 1: synchronous load of `D`.
- `D` input 4*DIGITS: load value; nibble k belongs to digit k.
- `VALUE` output 4*DIGITS: current count.
- `LED` output 1: toggles on every counted tick.
- `WRAP` output 1: 1-cycle pulse on count wrap-around.
- `DIG_SEL` output DIGITS: one-hot, active-high digit enable.
- `Segment` output 8: active-high segments. Bits [6:0] = g..a; bit 7 = DP, always 0.

## Operation
- **Reset (`RST_N`=0, asynchronous):**
  - Prescaler = 0, tick = 0, `VALUE` = 0, `LED` = 0, `WRAP` = 0.
  - Scan counter = 0, scan index = 0, `DIG_SEL` = 1, `Segment` = 8'h3F.
- **Prescaler:**
  - 32-bit counter. When `EN`=1 it counts 0..`TICK_DIV`-1, wraps to 0, and registers tick=1 for the wrap cycle only.
  - When `EN`=0 it holds its value and tick is 0.
- **Count update priority, per edge:**
  1. `CLR`: `VALUE`←0, `LED`←0, prescaler←0, tick←0, `WRAP`←0.
  2. `LOAD`: `VALUE`←`D`. The prescaler is unaffected.
  3. tick=1 and `EN`=1: count one step, `LED`←~`LED`.
  4. Otherwise hold.
- **Hex mode:** `VALUE` is a plain 4*DIGITS-bit modular counter.
  - Up from all-F gives 0 with `WRAP`=1.
  - Down from 0 gives all-F with `WRAP`=1.
- **BCD mode:** nibble ripple carry/borrow.
  - Up: a nibble ≥9 becomes 0 and carries; otherwise it increments.
  - Down: a nibble of 0 becomes 9 and borrows; a nibble >9 becomes 9 with no borrow; otherwise it decrements.
  - `WRAP`=1 when a carry or borrow leaves the top digit (99..9→0, 0→99..9).
  - An invalid nibble (>9) is accepted by `LOAD` as-is.
- **`WRAP`:** registered and asserted only on the edge that performs the wrapping step; 0 on every other edge.
- **Scan:**
  - The scan counter counts 0..`SCAN_DIV`-1. On wrap, the index advances 0→1→…→DIGITS-1→0.
  - Every edge: `DIG_SEL`←1<<index, `Segment`←enc(nibble[index]) or 8'h00 if blanked.
- **Leading-zero blanking:** when `BLANK_LZ`=1, digit k>0 is blanked if nibbles k..DIGITS-1 are all 0.
- **Encoding:** 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 27, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
- **Scan independence:** scanning ignores `EN`, `CLR` and `LOAD`.

## Timing
- First tick: with `EN`=1 from reset release, tick is high on edge `TICK_DIV`, and `VALUE`/`LED` change on edge `TICK_DIV`+1.
- Tick period: ticks then repeat every `TICK_DIV` cycles.
- `CLR`/`LOAD` latency: visible on `VALUE` 1 cycle after the sampling edge.
- Display latency: `DIG_SEL`/`Segment` lag the index or `VALUE` by 1 cycle and always change together, never skewed.
- Simultaneous `LOAD` and tick: `LOAD` wins, the tick is consumed, and `LED` does not toggle.
- Simultaneous `CLR` and anything: `CLR` wins.
- `EN` falling exactly on a tick cycle: no count, and the tick is dropped.
- Reset asserted mid-count or mid-scan: all outputs go to their reset values immediately, with no clock required.
- `DIGITS`=1: `DIG_SEL` is constantly 1.

## Test plan
- **Reset:** `RST_N` pulsed low between clock edges mid-count (`VALUE`=0x0007) → `VALUE`=0, `LED`=0, `WRAP`=0, `DIG_SEL`=4'b0001, `Segment`=8'h3F, all immediately.
- **Hex up count:** `CLK_FREQ`=20, `TICK_HZ`=2, `DIGITS`=4, `EN`=1, `UP_DN`=1 from reset → `VALUE`=0x0001 and `LED`=1 after edge 11; `VALUE`=0x0002 and `LED`=0 after edge 21.
- **BCD wrap:** `DECIMAL`=1, `DIGITS`=2.
  - `LOAD` 0x98, count up → 0x99, then 0x00 with `WRAP`=1 for exactly 1 cycle.
  - `UP_DN`=0 from 0x00 → 0x99 with `WRAP`=1.
  - `LOAD` 0x0C, count down → 0x09, no `WRAP`.
- **Pause / priority:**
  - `EN`=0 for 25 cycles → `VALUE` and prescaler frozen; after re-enable the next tick arrives `TICK_DIV` minus the elapsed pre-pause count.
  - `CLR`+`LOAD` together → `VALUE`=0.
  - `LOAD` on a tick cycle → `VALUE`=`D`, `LED` unchanged.
- **Scan:** `CLK_FREQ`=20, `SCAN_HZ`=1, `DIGITS`=4 (`SCAN_DIV`=5), `LOAD` 0x1A3F.
  - `DIG_SEL` steps 0001→0010→0100→1000→0001 every 5 cycles.
  - `Segment` = 71, 4F, 77, 06 respectively.
- **Leading-zero blanking:** `BLANK_LZ`=1, `LOAD` 0x0005 → `Segment` = 6D on digit 0 and 00 on digits 1–3. `LOAD` 0x0000 → digit 0 shows 3F.
